oled_draw_scheduler: RTL and testbench
======================================

# oled_draw_scheduler

Command scheduler that sits in front of the OLEDrgb SPI command driver and is the only block allowed to load its command slots. It replays a fixed SSD1331 power-on sequence after reset, then arbitrates between a full-screen clear requester and a single-pixel draw requester. Each request is turned into one driver transaction: load the command bytes, pulse start, wait for done, clear the buffer.

## Interface
Parameters:
- INIT_WAIT, default 5_000_000: clock cycles to wait after display-on before `o_ready` asserts (100 ms at 50 MHz).
- DONE_TIMEOUT, default 1_000_000: maximum clock cycles to wait for `i_done` after `o_start`.

Ports:
- `i_clk`  in  1  system clock; the only clock.
- `i_n_reset`  in  1  synchronous, active-low reset.
- `i_clr_req`  in  1  clear-screen request; level, held until acked.
- `o_clr_ack`  out  1  one-cycle pulse; clear request accepted.
- `i_pix_req`  in  1  pixel request; level, held until acked.
- `i_pix_x`  in  7  column, 0..95.
- `i_pix_y`  in  6  row, 0..63.
- `i_pix_color`  in  16  RGB565 colour.
- `o_pix_ack`  out  1  one-cycle pulse; pixel request consumed.
- `o_pix_err`  out  1  one-cycle pulse coincident with `o_pix_ack` when `i_pix_x` > 95; no transaction is issued.
- `o_ready`  out  1  init sequence complete; requests are serviced only while high.
- `o_fault`  out  1  sticky; set on a done timeout; cleared only by reset.
- `o_start`  out  1  one-cycle pulse to the driver.
- `o_cmd_reset`  out  1  one-cycle pulse to the driver; clears its byte buffer.
- `o_num_cmd`  out  4  byte count, 1..15.
- `o_cmd_1` … `o_cmd_15`  out  8 each  command bytes; unused slots are 0x00.
- `i_done`  in  1  driver completion pulse.

## Operation
- Reset: every output is 0 and all slots are 0x00. The FSM goes to INIT_LOAD with init index 0, and `o_fault` clears.
- Init ROM, in order, one transaction per entry (9 entries):
  1. [AE]
  2. [A0 72]
  3. [A1 00]
  4. [A2 00]
  5. [A4]
  6. [A8 3F]
  7. [AD 8E]
  8. [25 00 00 5F 3F]
  9. [AF]
- FSM states:
  - INIT_LOAD → START → WAIT_DONE → CLR_BUF → INIT_LOAD while the index is < 8. After entry 9, go to POWER_WAIT.
  - POWER_WAIT: count INIT_WAIT cycles, then set `o_ready` and go to IDLE.
  - IDLE: the clear request has priority. If `i_clr_req`, go to LOAD_CLR. Otherwise, if `i_pix_req`, go to LOAD_PIX.
  - LOAD_CLR: slots [25 00 00 5F 3F], num=5.
  - LOAD_PIX: slots [21 x y x y {R,0} {G} {B,0}], num=8. The bytes are R5<<1, G6, B5<<1, each zero-extended to 8 bits.
  - LOAD_x → START → WAIT_DONE → CLR_BUF → IDLE.
- Pixel row width: `i_pix_y` is 6 bits, so y is always in range.
- Out-of-range pixel: if x > 95, acknowledge with `o_pix_err` and stay in IDLE.
- Slot and count hold: slot values and `o_num_cmd` are held from LOAD until CLR_BUF, then return to 0x00 and 0.
- Timeout: a counter runs in WAIT_DONE. On reaching DONE_TIMEOUT, set `o_fault` and proceed to CLR_BUF as if done. The init sequence continues.
- `i_done` outside WAIT_DONE is ignored.
- Simultaneous requests: when both requests are high in IDLE, the clear is served first. The pixel request stays pending and is served on the next IDLE visit.
- Requests raised before `o_ready` are held off. They are not acked until the FSM is in IDLE.
- Reset asserted mid-transaction aborts immediately. Outputs go to their reset values and init restarts from entry 1. No `o_cmd_reset` pulse is emitted for the aborted transaction.

## Timing
- Request accept: with the request high in IDLE at cycle N:
  - ack (and err, if applicable) pulses at N+1;
  - the LOAD state, with slots and num valid, is at N+1;
  - `o_start` is high for cycle N+2 only;
  - WAIT_DONE begins at N+3.
- Request inputs are sampled at N only. `i_pix_x`, `i_pix_y` and `i_pix_color` may change from N+1.
- Done: `i_done` high at cycle M in WAIT_DONE gives `o_cmd_reset` high at M+1 only (CLR_BUF). Slots clear at M+2, and the FSM is in IDLE or the next INIT_LOAD at M+2.
- Best-case back-to-back service: a new ack at M+3.
- `o_ready` rises exactly INIT_WAIT+1 cycles after the CLR_BUF of entry 9.
- Slots are stable for the whole period from `o_start` to `i_done`.

## Test plan
- Reset then init, with INIT_WAIT=10 and a driver model returning `i_done` 5 cycles after start:
  - expect 9 starts with num = 1,2,2,2,1,2,2,5,1;
  - expect the byte sequences listed in Operation;
  - `o_ready` rises 11 cycles after the last CLR_BUF.
- Pixel (10,20,0xF800) after ready: expect num=8 and slots [21 0A 14 0A 14 3E 00 00]. Ack, start and cmd_reset follow the N+1, N+2 and M+1 cycles above.
- `i_clr_req` and `i_pix_req` rise in the same cycle:
  - the clear transaction [25 00 00 5F 3F] runs first;
  - the pixel is acked 3 cycles after the clear's `i_done`.
- Pixel x=96: `o_pix_ack` and `o_pix_err` pulse together. No `o_start` follows and the FSM stays in IDLE.
- Driver never returns done, with DONE_TIMEOUT=20: `o_fault` sets 20 cycles into WAIT_DONE, `o_cmd_reset` pulses, and init proceeds to the next entry.
- Reset asserted during WAIT_DONE of init entry 4: outputs return to reset values, and the next start carries [AE] with num=1.

Source files
------------

// File: rtl/oled_draw_scheduler.sv
// oled_draw_scheduler
//   Command scheduler in front of the OLEDrgb SPI command driver. After reset
//   it replays the SSD1331 power-on sequence, one driver transaction per
//   entry. It then waits INIT_WAIT cycles and raises o_ready. From then on it
//   serves clear-screen requests and single-pixel requests. A clear request
//   wins when both requests are pending.
//   Each driver transaction runs as: load slots -> start -> wait done ->
//   clear the driver buffer.
// Ports
//   i_clk, i_n_reset        clock, synchronous active-low reset
//   i_clr_req / o_clr_ack   clear request (level) / accept pulse
//   i_pix_req / o_pix_ack   pixel request (level) / consume pulse
//   i_pix_x/_y/_color       pixel coordinate and RGB565 colour
//   o_pix_err               pulses with o_pix_ack when x > 95 (nothing issued)
//   o_ready                 init sequence complete
//   o_fault                 sticky done-timeout flag
//   o_start, o_cmd_reset    one-cycle driver strobes
//   o_num_cmd, o_cmd_1..15  byte count and command bytes for the driver
//   i_done                  driver completion pulse
module oled_draw_scheduler #(
  parameter int unsigned INIT_WAIT    = 5_000_000,
  parameter int unsigned DONE_TIMEOUT = 1_000_000
) (
  input  logic        i_clk,
  input  logic        i_n_reset,
  input  logic        i_clr_req,
  output logic        o_clr_ack,
  input  logic        i_pix_req,
  input  logic [6:0]  i_pix_x,
  input  logic [5:0]  i_pix_y,
  input  logic [15:0] i_pix_color,
  output logic        o_pix_ack,
  output logic        o_pix_err,
  output logic        o_ready,
  output logic        o_fault,
  output logic        o_start,
  output logic        o_cmd_reset,
  output logic [3:0]  o_num_cmd,
  output logic [7:0]  o_cmd_1,
  output logic [7:0]  o_cmd_2,
  output logic [7:0]  o_cmd_3,
  output logic [7:0]  o_cmd_4,
  output logic [7:0]  o_cmd_5,
  output logic [7:0]  o_cmd_6,
  output logic [7:0]  o_cmd_7,
  output logic [7:0]  o_cmd_8,
  output logic [7:0]  o_cmd_9,
  output logic [7:0]  o_cmd_10,
  output logic [7:0]  o_cmd_11,
  output logic [7:0]  o_cmd_12,
  output logic [7:0]  o_cmd_13,
  output logic [7:0]  o_cmd_14,
  output logic [7:0]  o_cmd_15,
  input  logic        i_done
);

  typedef enum logic [2:0] {
    S_INIT_LOAD, S_START, S_WAIT_DONE, S_CLR_BUF,
    S_POWER_WAIT, S_IDLE, S_LOAD_CLR, S_LOAD_PIX
  } state_t;

  localparam logic [31:0] INIT_LAST = 32'(INIT_WAIT - 1);
  localparam logic [31:0] DONE_LAST = 32'(DONE_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  slots_q [15];
  logic [7:0]  slots_d [15];
  logic [3:0]  num_q, num_d;
  logic        ready_q, ready_d;
  logic        fault_q, fault_d;
  logic        start_q, start_d;
  logic        cmd_reset_q, cmd_reset_d;
  logic        clr_ack_q, clr_ack_d;
  logic        pix_ack_q, pix_ack_d;
  logic        pix_err_q, pix_err_d;
  logic [43:0] rom_word;  // {count, up to five bytes, left-justified}

  // SSD1331 power-on sequence
  function automatic logic [43:0] init_rom(input logic [3:0] idx);
    case (idx)
      4'd0:    init_rom = {4'd1, 40'hAE_00_00_00_00};
      4'd1:    init_rom = {4'd2, 40'hA0_72_00_00_00};
      4'd2:    init_rom = {4'd2, 40'hA1_00_00_00_00};
      4'd3:    init_rom = {4'd2, 40'hA2_00_00_00_00};
      4'd4:    init_rom = {4'd1, 40'hA4_00_00_00_00};
      4'd5:    init_rom = {4'd2, 40'hA8_3F_00_00_00};
      4'd6:    init_rom = {4'd2, 40'hAD_8E_00_00_00};
      4'd7:    init_rom = {4'd5, 40'h25_00_00_5F_3F};
      default: init_rom = {4'd1, 40'hAF_00_00_00_00};
    endcase
  endfunction

  assign rom_word = init_rom(idx_q);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    slots_d     = slots_q;
    num_d       = num_q;
    ready_d     = ready_q;
    fault_d     = fault_q;
    start_d     = 1'b0;
    cmd_reset_d = 1'b0;
    clr_ack_d   = 1'b0;
    pix_ack_d   = 1'b0;
    pix_err_d   = 1'b0;
    case (state_q)
      S_INIT_LOAD: begin
        num_d      = rom_word[43:40];
        slots_d[0] = rom_word[39:32];
        slots_d[1] = rom_word[31:24];
        slots_d[2] = rom_word[23:16];
        slots_d[3] = rom_word[15:8];
        slots_d[4] = rom_word[7:0];
        start_d    = 1'b1;
        state_d    = S_START;
      end
      S_LOAD_CLR, S_LOAD_PIX: begin
        // slots were captured on the IDLE->LOAD edge; only the strobe remains
        start_d = 1'b1;
        state_d = S_START;
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (i_done) begin
          cmd_reset_d = 1'b1;
          state_d     = S_CLR_BUF;
        end else if (cnt_q == DONE_LAST) begin
          // treat a lost done as completion so the sequence keeps moving
          fault_d     = 1'b1;
          cmd_reset_d = 1'b1;
          state_d     = S_CLR_BUF;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_CLR_BUF: begin
        for (int i = 0; i < 15; i++) slots_d[i] = 8'h00;
        num_d = 4'd0;
        cnt_d = '0;
        // ready is still low while the init ROM is being replayed
        if (ready_q) begin
          state_d = S_IDLE;
        end else if (idx_q < 4'd8) begin
          idx_d   = idx_q + 4'd1;
          state_d = S_INIT_LOAD;
        end else begin
          state_d = S_POWER_WAIT;
        end
      end
      S_POWER_WAIT: begin
        if (cnt_q == INIT_LAST) begin
          ready_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_IDLE: begin
        if (i_clr_req) begin
          clr_ack_d  = 1'b1;
          num_d      = 4'd5;
          slots_d[0] = 8'h25;
          slots_d[1] = 8'h00;
          slots_d[2] = 8'h00;
          slots_d[3] = 8'h5F;
          slots_d[4] = 8'h3F;
          state_d    = S_LOAD_CLR;
        end else if (i_pix_req) begin
          pix_ack_d = 1'b1;
          if (i_pix_x > 7'd95) begin
            pix_err_d = 1'b1;
          end else begin
            num_d      = 4'd8;
            slots_d[0] = 8'h21;
            slots_d[1] = {1'b0, i_pix_x};
            slots_d[2] = {2'b00, i_pix_y};
            slots_d[3] = {1'b0, i_pix_x};
            slots_d[4] = {2'b00, i_pix_y};
            slots_d[5] = {2'b00, i_pix_color[15:11], 1'b0};
            slots_d[6] = {2'b00, i_pix_color[10:5]};
            slots_d[7] = {2'b00, i_pix_color[4:0], 1'b0};
            state_d    = S_LOAD_PIX;
          end
        end
      end
      default: state_d = S_INIT_LOAD;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_n_reset) begin
      state_q     <= S_INIT_LOAD;
      idx_q       <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < 15; i++) slots_q[i] <= 8'h00;
      num_q       <= '0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
      start_q     <= 1'b0;
      cmd_reset_q <= 1'b0;
      clr_ack_q   <= 1'b0;
      pix_ack_q   <= 1'b0;
      pix_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      slots_q     <= slots_d;
      num_q       <= num_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
      start_q     <= start_d;
      cmd_reset_q <= cmd_reset_d;
      clr_ack_q   <= clr_ack_d;
      pix_ack_q   <= pix_ack_d;
      pix_err_q   <= pix_err_d;
    end
  end

  assign o_clr_ack   = clr_ack_q;
  assign o_pix_ack   = pix_ack_q;
  assign o_pix_err   = pix_err_q;
  assign o_ready     = ready_q;
  assign o_fault     = fault_q;
  assign o_start     = start_q;
  assign o_cmd_reset = cmd_reset_q;
  assign o_num_cmd   = num_q;
  assign o_cmd_1     = slots_q[0];
  assign o_cmd_2     = slots_q[1];
  assign o_cmd_3     = slots_q[2];
  assign o_cmd_4     = slots_q[3];
  assign o_cmd_5     = slots_q[4];
  assign o_cmd_6     = slots_q[5];
  assign o_cmd_7     = slots_q[6];
  assign o_cmd_8     = slots_q[7];
  assign o_cmd_9     = slots_q[8];
  assign o_cmd_10    = slots_q[9];
  assign o_cmd_11    = slots_q[10];
  assign o_cmd_12    = slots_q[11];
  assign o_cmd_13    = slots_q[12];
  assign o_cmd_14    = slots_q[13];
  assign o_cmd_15    = slots_q[14];

endmodule

// File: tb/tb_oled_draw_scheduler.sv
// Testbench for oled_draw_scheduler.
// The stimulus process queues the expected driver transactions and acks.
// A monitor pops and compares an entry whenever the DUT issues o_start or
// an ack. The stimulus process makes the cycle-relationship checks itself.
module tb_oled_draw_scheduler;
  logic        clk;
  logic        i_n_reset;
  logic        i_clr_req, i_pix_req, i_done;
  logic [6:0]  i_pix_x;
  logic [5:0]  i_pix_y;
  logic [15:0] i_pix_color;
  logic        o_clr_ack, o_pix_ack, o_pix_err, o_ready, o_fault, o_start, o_cmd_reset;
  logic [3:0]  o_num_cmd;
  logic [7:0]  c1, c2, c3, c4, c5, c6, c7, c8, c9, c10, c11, c12, c13, c14, c15;

  oled_draw_scheduler #(.INIT_WAIT(10), .DONE_TIMEOUT(20)) dut (
    .i_clk(clk), .i_n_reset(i_n_reset),
    .i_clr_req(i_clr_req), .o_clr_ack(o_clr_ack),
    .i_pix_req(i_pix_req), .i_pix_x(i_pix_x), .i_pix_y(i_pix_y),
    .i_pix_color(i_pix_color), .o_pix_ack(o_pix_ack), .o_pix_err(o_pix_err),
    .o_ready(o_ready), .o_fault(o_fault), .o_start(o_start),
    .o_cmd_reset(o_cmd_reset), .o_num_cmd(o_num_cmd),
    .o_cmd_1(c1), .o_cmd_2(c2), .o_cmd_3(c3), .o_cmd_4(c4), .o_cmd_5(c5),
    .o_cmd_6(c6), .o_cmd_7(c7), .o_cmd_8(c8), .o_cmd_9(c9), .o_cmd_10(c10),
    .o_cmd_11(c11), .o_cmd_12(c12), .o_cmd_13(c13), .o_cmd_14(c14), .o_cmd_15(c15),
    .i_done(i_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int errs = 0;
  logic [127:0] start_q [$];
  logic [2:0]   ack_q [$];
  int n_start = 0, n_ack = 0, n_crst = 0;
  int start_cyc = 0, ack_cyc = 0, crst_cyc = 0, done_cyc = 0, ready_cyc = 0, fault_cyc = 0;
  logic ready_prev = 1'b0, fault_prev = 1'b0;
  logic drv_en = 1'b1;

  // Expected init transactions: {count, eight bytes left-justified}
  logic [67:0] init_tab [9] = '{
    68'h1_AE00000000000000, 68'h2_A072000000000000, 68'h2_A100000000000000,
    68'h2_A200000000000000, 68'h1_A400000000000000, 68'h2_A83F000000000000,
    68'h2_AD8E000000000000, 68'h5_2500005F3F000000, 68'h1_AF00000000000000};

  function automatic logic [127:0] ev(input logic [67:0] e);
    return {4'h0, e[67:64], e[63:0], 56'h0};
  endfunction

  function automatic logic [127:0] slot_vec();
    return {4'h0, o_num_cmd, c1, c2, c3, c4, c5, c6, c7, c8,
            c9, c10, c11, c12, c13, c14, c15};
  endfunction

  function automatic logic [127:0] all_vec();
    return {slot_vec(), o_ready, o_fault, o_start, o_cmd_reset,
            o_clr_ack, o_pix_ack, o_pix_err};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Driver model: i_done pulses 5 cycles after a start, unless disabled
  initial begin
    int dly;
    dly = 0;
    i_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      i_done = 1'b0;
      if (!i_n_reset) dly = 0;
      else if (dly != 0) begin
        dly--;
        if (dly == 0) i_done = 1'b1;
      end else if (o_start && drv_en) dly = 5;
    end
  end

  // Monitor / scoreboard
  initial begin
    logic [127:0] e;
    logic [2:0]   a;
    forever begin
      @(negedge clk);
      if (o_start) begin
        n_start++;
        start_cyc = cyc;
        $display("cycle %0d start num=%0d bytes=%0h", cyc, o_num_cmd, slot_vec());
        if (start_q.size() == 0) chk("unexpected_start", slot_vec(), 128'h0);
        else begin
          e = start_q.pop_front();
          chk("start_slots", slot_vec(), e);
        end
      end
      if (o_clr_ack || o_pix_ack || o_pix_err) begin
        n_ack++;
        ack_cyc = cyc;
        $display("cycle %0d ack clr=%0b pix=%0b err=%0b", cyc, o_clr_ack, o_pix_ack, o_pix_err);
        if (ack_q.size() == 0) chk("unexpected_ack", {125'h0, o_clr_ack, o_pix_ack, o_pix_err}, 128'h0);
        else begin
          a = ack_q.pop_front();
          chk("ack_flags", {125'h0, o_clr_ack, o_pix_ack, o_pix_err}, {125'h0, a});
        end
      end
      if (i_done) done_cyc = cyc;
      if (o_cmd_reset) begin n_crst++; crst_cyc = cyc; end
      if (o_ready && !ready_prev) ready_cyc = cyc;
      if (o_fault && !fault_prev) fault_cyc = cyc;
      ready_prev = o_ready;
      fault_prev = o_fault;
    end
  end

  function automatic int cur(input int sel);
    case (sel)
      0: return n_start;
      1: return n_ack;
      2: return n_crst;
      default: return o_ready ? 1 : 0;
    endcase
  endfunction

  task automatic wait_cnt(input int sel, input int target, input string name);
    int t;
    t = 0;
    while (cur(sel) < target && t < 300) begin
      @(negedge clk); #1;
      t++;
    end
    if (cur(sel) < target) begin
      vectors++;
      errs++;
      $display("FAIL wait_%s: got %0d expected %0d", name, cur(sel), target);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  initial begin
    int n_c, s0, a0, c0, b0;
    i_n_reset = 1'b0; i_clr_req = 1'b0; i_pix_req = 1'b0;
    i_pix_x = '0; i_pix_y = '0; i_pix_color = '0;
    step(3);
    chk("reset_outputs", all_vec(), 128'h0);

    // Power-on sequence
    for (int i = 0; i < 9; i++) start_q.push_back(ev(init_tab[i]));
    i_n_reset = 1'b1;
    wait_cnt(0, 9, "init_starts");
    wait_cnt(3, 1, "ready");
    chk("ready_delay", 128'(ready_cyc - crst_cyc), 128'd11);
    chk("init_cmd_resets", 128'(n_crst), 128'd9);

    // Pixel (10,20,red); inputs change right after the accept cycle
    start_q.push_back(ev(68'h8_210A140A143E0000));
    ack_q.push_back(3'b010);
    i_pix_req = 1'b1; i_pix_x = 7'd10; i_pix_y = 6'd20; i_pix_color = 16'hF800;
    n_c = cyc; a0 = n_ack; s0 = n_start; c0 = n_crst;
    wait_cnt(1, a0 + 1, "pix_ack");
    i_pix_req = 1'b0; i_pix_x = 7'd0; i_pix_y = 6'd0; i_pix_color = 16'h0;
    chk("pix_ack_cycle", 128'(ack_cyc), 128'(n_c + 1));
    wait_cnt(2, c0 + 1, "pix_cmd_reset");
    chk("pix_start_cycle", 128'(start_cyc), 128'(n_c + 2));
    chk("pix_cmd_reset_cycle", 128'(crst_cyc), 128'(n_c + 8));
    chk("pix_done_to_cmd_reset", 128'(crst_cyc - done_cyc), 128'd1);
    step(1);
    chk("pix_slots_cleared", slot_vec(), 128'h0);
    step(1);

    // Clear and pixel in the same cycle: clear first
    start_q.push_back(ev(68'h5_2500005F3F000000));
    start_q.push_back(ev(68'h8_2105060506003F00));
    ack_q.push_back(3'b100);
    ack_q.push_back(3'b010);
    a0 = n_ack; c0 = n_crst;
    i_clr_req = 1'b1; i_pix_req = 1'b1;
    i_pix_x = 7'd5; i_pix_y = 6'd6; i_pix_color = 16'h07E0;
    wait_cnt(1, a0 + 1, "clr_ack");
    i_clr_req = 1'b0;
    wait_cnt(1, a0 + 2, "pending_pix_ack");
    i_pix_req = 1'b0;
    chk("pix_after_clear_delay", 128'(ack_cyc - done_cyc), 128'd3);
    wait_cnt(2, c0 + 2, "both_cmd_resets");
    step(2);

    // Out-of-range column
    ack_q.push_back(3'b011);
    a0 = n_ack; s0 = n_start;
    i_pix_req = 1'b1; i_pix_x = 7'd96; i_pix_y = 6'd1; i_pix_color = 16'hFFFF;
    n_c = cyc;
    wait_cnt(1, a0 + 1, "err_ack");
    i_pix_req = 1'b0;
    chk("err_ack_cycle", 128'(ack_cyc), 128'(n_c + 1));
    step(10);
    chk("err_no_start", 128'(n_start), 128'(s0));
    chk("err_single_ack", 128'(n_ack), 128'(a0 + 1));

    // Reset during WAIT_DONE of init entry 4
    i_n_reset = 1'b0;
    step(2);
    for (int i = 0; i < 4; i++) start_q.push_back(ev(init_tab[i]));
    s0 = n_start;
    i_n_reset = 1'b1;
    wait_cnt(0, s0 + 4, "init_to_entry4");
    step(2);
    i_n_reset = 1'b0;
    step(1);
    chk("midtx_reset_outputs", all_vec(), 128'h0);
    step(1);

    // Next init: entry 1 gets no done and must time out
    drv_en = 1'b0;
    for (int i = 0; i < 9; i++) start_q.push_back(ev(init_tab[i]));
    s0 = n_start; c0 = n_crst;
    i_n_reset = 1'b1;
    wait_cnt(0, s0 + 1, "restart_start");
    b0 = start_cyc;
    wait_cnt(2, c0 + 1, "timeout_cmd_reset");
    drv_en = 1'b1;
    chk("fault_cycle", 128'(fault_cyc), 128'(b0 + 21));
    chk("timeout_cmd_reset_cycle", 128'(crst_cyc), 128'(b0 + 21));
    wait_cnt(3, 1, "ready_after_fault");
    chk("fault_sticky", 128'(o_fault), 128'd1);
    chk("start_queue_drained", 128'(start_q.size()), 128'd0);
    chk("ack_queue_drained", 128'(ack_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
